// File: rtl/pc_seq_pkg.sv
// Shared definitions for the PC sequencer: default vectors, FSM state and exception cause types.
package pc_seq_pkg;

    localparam logic [31:0] RESETPC_DEF = 32'h0000_0000;
    localparam logic [31:0] ILLOP_DEF   = 32'h8000_0004;
    localparam logic [31:0] XADR_DEF    = 32'h8000_0008;

    typedef enum logic {
        RUN = 1'b0,
        EXC = 1'b1
    } state_t;

    typedef enum logic {
        C_ILLOP = 1'b0,
        C_IRQ   = 1'b1
    } cause_t;

    // Sequential fetch stays inside the current half of the address space.
    function automatic logic [31:0] next_seq(input logic [31:0] cur);
        return {cur[31], cur[30:0] + 31'd4};
    endfunction

endpackage

// File: rtl/pc_seq_prio.sv
// Purpose: RUN-state next-PC priority decision (branch > exception > eret > jump > sequential).
// Latency: purely combinational, zero cycles.
// Backpressure: stall blocks eret/jump/sequential writes; branch and exception override it.
module pc_seq_prio
    import pc_seq_pkg::*;
(
    input  logic [31:0] pc,
    input  logic        stall,
    input  logic        br_req,
    input  logic [31:0] br_target,
    input  logic        jmp_req,
    input  logic [31:0] jmp_target,
    input  logic        illop,
    input  logic        irq_take,
    input  logic        eret,
    input  logic [31:0] epc,
    output logic [31:0] pc_next,
    output logic        pc_wr,
    output logic        flush_if,
    output logic        flush_id,
    output logic        exc_take,
    output logic        exc_irq,
    output logic        eret_take
);

    always_comb begin
        pc_next   = next_seq(pc);
        pc_wr     = ~stall;
        flush_if  = 1'b0;
        flush_id  = 1'b0;
        exc_take  = 1'b0;
        exc_irq   = 1'b0;
        eret_take = 1'b0;
        if (br_req) begin
            pc_next  = br_target;
            pc_wr    = 1'b1;
            flush_if = 1'b1;
            flush_id = 1'b1;
        end else if (illop || irq_take) begin
            // PC is frozen this cycle; the vector is written from EXC next cycle.
            pc_wr    = 1'b0;
            flush_if = 1'b1;
            flush_id = 1'b1;
            exc_take = 1'b1;
            exc_irq  = ~illop;
        end else if (!stall && eret) begin
            pc_next   = epc;
            flush_if  = 1'b1;
            eret_take = 1'b1;
        end else if (!stall && jmp_req) begin
            pc_next  = jmp_target;
            flush_if = 1'b1;
        end
    end

endmodule

// File: rtl/pc_seq.sv
// Purpose: PC sequencer with two-state exception FSM (RUN/EXC); irq path enabled by PC_SEQ_IRQ_EN.
// Latency: outputs combinational; exception vector written 2 cycles after the accepting edge.
// Backpressure: stall holds the PC except for branches and exception entry.
module pc_seq
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESETPC = RESETPC_DEF,
    parameter logic [31:0] ILLOP   = ILLOP_DEF,
    parameter logic [31:0] XADR    = XADR_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic [31:0] id_pc,
    input  logic        stall,
    input  logic        br_req,
    input  logic [31:0] br_target,
    input  logic        jmp_req,
    input  logic [31:0] jmp_target,
    input  logic        illop,
    input  logic        irq,
    input  logic        eret,
    output logic [31:0] pc_next,
    output logic        pc_wr,
    output logic        flush_if,
    output logic        flush_id,
    output logic [31:0] epc,
    output logic        busy
);

    state_t      state;
    logic [31:0] epc_q;
    logic [31:0] run_next;
    logic        run_wr;
    logic        run_fif;
    logic        run_fid;
    logic        exc_take;
    logic        exc_irq;
    logic        eret_take;
    logic        irq_take;
    logic [31:0] vector;

`ifdef PC_SEQ_IRQ_EN
    logic   irq_pend;
    logic   eret_q;
    cause_t cause_q;

    // Interrupts are only taken from user mode and never right after an eret.
    assign irq_take = irq_pend & ~pc[31] & ~eret_q & (state == RUN);
    assign vector   = (cause_q == C_IRQ) ? XADR : ILLOP;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_pend <= 1'b0;
            eret_q   <= 1'b0;
            cause_q  <= C_ILLOP;
        end else if (state == EXC) begin
            if (cause_q == C_IRQ)
                irq_pend <= 1'b0;
            eret_q <= 1'b0;
        end else begin
            irq_pend <= irq_pend | irq;
            eret_q   <= eret_take;
            if (exc_take)
                cause_q <= exc_irq ? C_IRQ : C_ILLOP;
        end
    end
`else
    logic unused_irq;

    assign irq_take   = 1'b0;
    assign vector     = ILLOP;
    assign unused_irq = irq ^ exc_irq ^ eret_take ^ (^XADR);
`endif

    pc_seq_prio u_prio (
        .pc         (pc),
        .stall      (stall),
        .br_req     (br_req),
        .br_target  (br_target),
        .jmp_req    (jmp_req),
        .jmp_target (jmp_target),
        .illop      (illop),
        .irq_take   (irq_take),
        .eret       (eret),
        .epc        (epc_q),
        .pc_next    (run_next),
        .pc_wr      (run_wr),
        .flush_if   (run_fif),
        .flush_id   (run_fid),
        .exc_take   (exc_take),
        .exc_irq    (exc_irq),
        .eret_take  (eret_take)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RUN;
            epc_q <= '0;
        end else if (state == EXC) begin
            state <= RUN;
        end else if (exc_take) begin
            state <= EXC;
            epc_q <= id_pc;
        end
    end

    always_comb begin
        pc_next  = run_next;
        pc_wr    = run_wr;
        flush_if = run_fif;
        flush_id = run_fid;
        busy     = 1'b0;
        if (!reset) begin
            pc_next  = RESETPC;
            pc_wr    = 1'b0;
            flush_if = 1'b0;
            flush_id = 1'b0;
        end else if (state == EXC) begin
            pc_next  = vector;
            pc_wr    = 1'b1;
            flush_if = 1'b1;
            flush_id = 1'b0;
            busy     = 1'b1;
        end
    end

    assign epc = epc_q;

endmodule

// File: tb/tb_pc_seq.sv
// Bench for pc_seq: hand-derived vector table, multi-cycle corner sequences, then random traffic vs a reference model.
module tb_pc_seq;

    localparam logic [31:0] V_RESET = 32'h0000_0000;
    localparam logic [31:0] V_ILL   = 32'h8000_0004;
    localparam logic [31:0] V_IRQ   = 32'h8000_0008;

`ifdef PC_SEQ_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    typedef struct {
        logic        rst;
        logic [31:0] pc;
        logic [31:0] id_pc;
        logic        stall;
        logic        br;
        logic [31:0] brt;
        logic        jmp;
        logic [31:0] jmpt;
        logic        ill;
        logic        irq;
        logic        eret;
    } in_t;

    typedef struct {
        logic [31:0] nxt;
        logic        wr;
        logic        fif;
        logic        fid;
        logic        busy;
        logic [31:0] epc;
        logic        chk;
    } out_t;

    typedef struct {
        in_t  i;
        out_t o;
    } row_t;

    logic        clk;
    logic        rst;
    logic [31:0] pc, id_pc, br_target, jmp_target;
    logic        stall, br_req, jmp_req, illop, irq, eret;
    logic [31:0] pc_next, epc;
    logic        pc_wr, flush_if, flush_id, busy;

    int total = 0;
    int bad   = 0;

    // Reference model state: in handler-entry cycle, pending vector, saved PC, irq pending, eret just taken.
    logic        m_exc;
    logic [31:0] m_vec;
    logic [31:0] m_epc;
    logic        m_pend;
    logic        m_eret_prev;

    pc_seq dut (
        .clk        (clk),
        .reset      (rst),
        .pc         (pc),
        .id_pc      (id_pc),
        .stall      (stall),
        .br_req     (br_req),
        .br_target  (br_target),
        .jmp_req    (jmp_req),
        .jmp_target (jmp_target),
        .illop      (illop),
        .irq        (irq),
        .eret       (eret),
        .pc_next    (pc_next),
        .pc_wr      (pc_wr),
        .flush_if   (flush_if),
        .flush_id   (flush_id),
        .epc        (epc),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic in_t mk_in(logic r, logic [31:0] p, logic [31:0] idp, logic st, logic b,
                                  logic [31:0] bt, logic j, logic [31:0] jt, logic il, logic iq, logic er);
        in_t v;
        v.rst = r; v.pc = p; v.id_pc = idp; v.stall = st; v.br = b; v.brt = bt;
        v.jmp = j; v.jmpt = jt; v.ill = il; v.irq = iq; v.eret = er;
        return v;
    endfunction

    function automatic out_t mk_out(logic [31:0] n, logic w, logic fi, logic fd, logic bz,
                                    logic [31:0] e, logic c);
        out_t v;
        v.nxt = n; v.wr = w; v.fif = fi; v.fid = fd; v.busy = bz; v.epc = e; v.chk = c;
        return v;
    endfunction

    function automatic logic [31:0] plus4(logic [31:0] p);
        return (p & 32'h8000_0000) | ((p + 32'd4) & 32'h7FFF_FFFF);
    endfunction

    function automatic logic exc_now(in_t i);
        return i.ill || (IRQ_ON && m_pend && !i.pc[31] && !m_eret_prev);
    endfunction

    function automatic out_t model_out(in_t i);
        out_t o;
        o = mk_out(plus4(i.pc), 1'b0, 1'b0, 1'b0, 1'b0, m_epc, 1'b1);
        if (!i.rst) begin
            o.nxt = V_RESET;
            o.epc = 32'h0;
        end else if (m_exc) begin
            o = mk_out(m_vec, 1'b1, 1'b1, 1'b0, 1'b1, m_epc, 1'b1);
        end else if (i.br) begin
            o = mk_out(i.brt, 1'b1, 1'b1, 1'b1, 1'b0, m_epc, 1'b1);
        end else if (exc_now(i)) begin
            o = mk_out(32'h0, 1'b0, 1'b1, 1'b1, 1'b0, m_epc, 1'b0);
        end else if (!i.stall && i.eret) begin
            o = mk_out(m_epc, 1'b1, 1'b1, 1'b0, 1'b0, m_epc, 1'b1);
        end else if (!i.stall && i.jmp) begin
            o = mk_out(i.jmpt, 1'b1, 1'b1, 1'b0, 1'b0, m_epc, 1'b1);
        end else begin
            o.wr = !i.stall;
        end
        return o;
    endfunction

    task automatic model_edge(input in_t i);
        logic took_eret;
        took_eret = 1'b0;
        if (!i.rst) begin
            m_exc = 1'b0; m_pend = 1'b0; m_epc = 32'h0; m_eret_prev = 1'b0;
        end else if (m_exc) begin
            m_exc = 1'b0;
            if (m_vec == V_IRQ) m_pend = 1'b0;
            m_eret_prev = 1'b0;
        end else begin
            took_eret = !i.br && !exc_now(i) && !i.stall && i.eret;
            if (!i.br && exc_now(i)) begin
                m_exc = 1'b1;
                m_epc = i.id_pc;
                m_vec = i.ill ? V_ILL : V_IRQ;
            end
            m_pend      = m_pend | (IRQ_ON & i.irq);
            m_eret_prev = took_eret;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic check(input string nm, input out_t e);
        if (e.chk) chk({nm, ".pc_next"}, pc_next, e.nxt);
        chk({nm, ".pc_wr"},    32'(pc_wr),    32'(e.wr));
        chk({nm, ".flush_if"}, 32'(flush_if), 32'(e.fif));
        chk({nm, ".flush_id"}, 32'(flush_id), 32'(e.fid));
        chk({nm, ".busy"},     32'(busy),     32'(e.busy));
        chk({nm, ".epc"},      epc,           e.epc);
    endtask

    task automatic apply(input in_t i);
        rst = i.rst; pc = i.pc; id_pc = i.id_pc; stall = i.stall; br_req = i.br;
        br_target = i.brt; jmp_req = i.jmp; jmp_target = i.jmpt; illop = i.ill;
        irq = i.irq; eret = i.eret;
    endtask

    task automatic cycle(input string nm, input in_t i, input out_t e);
        apply(i);
        @(negedge clk);
        check(nm, e);
        @(posedge clk);
        #1;
    endtask

    row_t tbl[14];
    in_t  ri;

    initial begin
        apply(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        tbl[0]  = '{mk_in(0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0),            mk_out(32'h0, 0, 0, 0, 0, 0, 1)};
        tbl[1]  = '{mk_in(1, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0),            mk_out(32'h4, 1, 0, 0, 0, 0, 1)};
        tbl[2]  = '{mk_in(1, 32'h10, 0, 1, 1, 32'h100, 0, 0, 0, 0, 0),     mk_out(32'h100, 1, 1, 1, 0, 0, 1)};
        tbl[3]  = '{mk_in(1, 32'h10, 0, 1, 0, 0, 0, 0, 0, 0, 0),           mk_out(32'h14, 0, 0, 0, 0, 0, 1)};
        tbl[4]  = '{mk_in(1, 32'h7FFF_FFFC, 0, 0, 0, 0, 0, 0, 0, 0, 0),    mk_out(32'h0, 1, 0, 0, 0, 0, 1)};
        tbl[5]  = '{mk_in(1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0, 0, 0, 0),    mk_out(32'h8000_0000, 1, 0, 0, 0, 0, 1)};
        tbl[6]  = '{mk_in(1, 32'h100, 0, 0, 0, 0, 1, 32'h200, 0, 0, 0),    mk_out(32'h200, 1, 1, 0, 0, 0, 1)};
        tbl[7]  = '{mk_in(1, 32'h100, 0, 1, 0, 0, 1, 32'h200, 0, 0, 0),    mk_out(32'h104, 0, 0, 0, 0, 0, 1)};
        tbl[8]  = '{mk_in(1, 32'h100, 32'h99, 0, 1, 32'h300, 0, 0, 1, 0, 0), mk_out(32'h300, 1, 1, 1, 0, 0, 1)};
        tbl[9]  = '{mk_in(1, 32'h104, 32'h20, 1, 0, 0, 0, 0, 1, 0, 0),     mk_out(32'h0, 0, 1, 1, 0, 0, 0)};
        tbl[10] = '{mk_in(1, 32'h108, 32'h77, 0, 0, 0, 1, 32'h900, 1, 0, 0), mk_out(V_ILL, 1, 1, 0, 1, 32'h20, 1)};
        tbl[11] = '{mk_in(1, 32'h8000_0004, 0, 0, 0, 0, 0, 0, 0, 0, 1),    mk_out(32'h20, 1, 1, 0, 0, 32'h20, 1)};
        tbl[12] = '{mk_in(1, 32'h20, 0, 0, 0, 0, 1, 32'h500, 0, 0, 1),     mk_out(32'h20, 1, 1, 0, 0, 32'h20, 1)};
        tbl[13] = '{mk_in(1, 32'h24, 0, 1, 0, 0, 0, 0, 0, 0, 1),           mk_out(32'h28, 0, 0, 0, 0, 32'h20, 1)};

        for (int k = 0; k < 14; k++)
            cycle($sformatf("tbl%0d", k), tbl[k].i, tbl[k].o);

        // Interrupt raised in kernel mode, released by eret, taken one cycle after returning.
        cycle("irq_rst",  mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0),              mk_out(V_RESET, 0, 0, 0, 0, 0, 1));
        cycle("irq_ill",  mk_in(1, 32'h8, 32'h40, 0, 0, 0, 0, 0, 1, 0, 0),     mk_out(0, 0, 1, 1, 0, 0, 0));
        cycle("irq_exc",  mk_in(1, 32'hC, 0, 0, 0, 0, 0, 0, 0, 0, 0),          mk_out(V_ILL, 1, 1, 0, 1, 32'h40, 1));
        cycle("irq_k1",   mk_in(1, 32'h8000_0004, 0, 0, 0, 0, 0, 0, 0, 1, 0),  mk_out(32'h8000_0008, 1, 0, 0, 0, 32'h40, 1));
        cycle("irq_k2",   mk_in(1, 32'h8000_0008, 0, 0, 0, 0, 0, 0, 0, 0, 0),  mk_out(32'h8000_000C, 1, 0, 0, 0, 32'h40, 1));
        cycle("irq_eret", mk_in(1, 32'h8000_000C, 0, 0, 0, 0, 0, 0, 0, 0, 1),  mk_out(32'h40, 1, 1, 0, 0, 32'h40, 1));
        cycle("irq_hold", mk_in(1, 32'h40, 32'h3C, 0, 0, 0, 0, 0, 0, 0, 0),   mk_out(32'h44, 1, 0, 0, 0, 32'h40, 1));
        if (IRQ_ON) begin
            cycle("irq_take", mk_in(1, 32'h44, 32'h44, 0, 0, 0, 0, 0, 0, 0, 0), mk_out(0, 0, 1, 1, 0, 32'h40, 0));
            cycle("irq_vec",  mk_in(1, 32'h44, 0, 0, 0, 0, 0, 0, 0, 0, 0),      mk_out(V_IRQ, 1, 1, 0, 1, 32'h44, 1));
            cycle("irq_clr",  mk_in(1, 32'h48, 0, 0, 0, 0, 0, 0, 0, 0, 0),      mk_out(32'h4C, 1, 0, 0, 0, 32'h44, 1));
        end else begin
            cycle("irq_off1", mk_in(1, 32'h44, 32'h44, 0, 0, 0, 0, 0, 0, 0, 0), mk_out(32'h48, 1, 0, 0, 0, 32'h40, 1));
            cycle("irq_off2", mk_in(1, 32'h48, 0, 0, 0, 0, 0, 0, 0, 0, 0),      mk_out(32'h4C, 1, 0, 0, 0, 32'h40, 1));
        end

        // Reset arriving while in EXC abandons the exception entirely.
        cycle("rx_ill",  mk_in(1, 32'h50, 32'h60, 0, 0, 0, 0, 0, 1, 0, 0), mk_out(0, 0, 1, 1, 0, IRQ_ON ? 32'h44 : 32'h40, 0));
        cycle("rx_rst",  mk_in(0, 32'h54, 0, 0, 0, 0, 0, 0, 0, 0, 0),      mk_out(V_RESET, 0, 0, 0, 0, 0, 1));
        cycle("rx_run",  mk_in(1, 32'h10, 0, 0, 0, 0, 0, 0, 0, 0, 0),      mk_out(32'h14, 1, 0, 0, 0, 0, 1));
        cycle("rx_run2", mk_in(1, 32'h14, 0, 0, 0, 0, 0, 0, 0, 0, 0),      mk_out(32'h18, 1, 0, 0, 0, 0, 1));

        m_exc = 1'b0; m_vec = V_ILL; m_epc = 32'h0; m_pend = 1'b0; m_eret_prev = 1'b0;
        for (int k = 0; k < 800; k++) begin
            ri = mk_in(k == 0 ? 1'b0 : ($urandom_range(0, 39) != 0), $urandom, $urandom,
                       ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0), $urandom,
                       ($urandom_range(0, 5) == 0), $urandom, ($urandom_range(0, 9) == 0),
                       ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0));
            if ($urandom_range(0, 1) == 0) ri.pc[31] = 1'b0;
            apply(ri);
            @(negedge clk);
            check($sformatf("rnd%0d", k), model_out(ri));
            model_edge(ri);
            @(posedge clk);
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_seq.md
PC_SEQ -- requirements
Module: pc_seq

Interface
REQ-001 SHALL have parameter RESETPC, default 32'h00000000, PC value driven while in reset.
REQ-002 SHALL have parameter ILLOP, default 32'h80000004, illegal-opcode handler vector.
REQ-003 SHALL have parameter XADR, default 32'h80000008, interrupt handler vector.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 pc  in  32  current PC register value.
REQ-007 id_pc  in  32  PC of the instruction in ID.
REQ-008 stall  in  1  load-use hazard hold.
REQ-009 br_req, br_target  in  1, 32  taken branch resolved in EX.
REQ-010 jmp_req, jmp_target  in  1, 32  jump decoded in ID.
REQ-011 illop  in  1  undefined opcode in ID.
REQ-012 irq  in  1  external interrupt, level.
REQ-013 eret  in  1  exception return decoded in ID.
REQ-014 pc_next  out  32  value to load into PC.
REQ-015 pc_wr  out  1  PC write enable.
REQ-016 flush_if, flush_id  out  1  bubble IF/ID and ID/EX registers.
REQ-017 epc  out  32  saved return address.
REQ-018 busy  out  1  high in state EXC.

Function
REQ-019 SHALL implement FSM states RUN and EXC.
REQ-020 RUN, no event: pc_wr = ~stall; pc_next = {pc[31], pc[30:0]+4}, carry out of bit 30 discarded; bit 31 preserved.
REQ-021 Priority in RUN SHALL be: br_req > exception (illop, then pending irq) > eret > jmp_req > sequential.
REQ-022 br_req SHALL give pc_wr=1, pc_next=br_target, flush_if=flush_id=1, and override stall in the same cycle.
REQ-023 When br_req and an exception coincide, the branch SHALL win; illop SHALL be dropped; a pending irq SHALL be kept.
REQ-024 jmp_req (not stalled) SHALL give pc_wr=1, pc_next=jmp_target, flush_if=1.
REQ-025 eret (not stalled) SHALL give pc_wr=1, pc_next=epc, flush_if=1.
REQ-026 irq SHALL set an irq_pend register.
REQ-027 irq_pend SHALL be taken only when pc[31]=0, state=RUN, and no eret was taken in the previous cycle.
REQ-028 Exception accepted in RUN: pc_wr=0, flush_if=flush_id=1, epc<=id_pc on the clock edge, next state EXC; this takes effect even if stall=1.
REQ-029 In EXC: pc_wr=1, pc_next=ILLOP or XADR (cause latched at entry), flush_if=1, irq_pend cleared if the cause was irq, next state RUN; all inputs are ignored.
REQ-030 Exception entry latency SHALL be 2 cycles from the accepting edge to the vector being written into the PC.
REQ-031 The handler vectors SHALL set pc[31]=1 (kernel); eret restores pc[31] from epc.
REQ-032 Outputs SHALL be combinational from state and inputs; epc, cause, irq_pend and state SHALL be registered.

Reset
REQ-033 reset low SHALL asynchronously force state=RUN, irq_pend=0, and epc=0.
REQ-034 While reset is low, outputs SHALL be pc_wr=0, flush_*=0, busy=0, pc_next=RESETPC.
REQ-035 Reset asserted during EXC SHALL abandon the exception; no vector is written.
REQ-036 After reset deasserts, the first edge SHALL behave as RUN.

Configuration
REQ-037 Macro PC_SEQ_IRQ_EN defined: the irq path is as specified above.
REQ-038 Macro PC_SEQ_IRQ_EN undefined: irq is ignored; irq_pend and XADR logic are absent; illop, eret, branch and jump are unchanged.

Structure
REQ-039 Shared package pc_seq_pkg SHALL hold the RESETPC/ILLOP/XADR defaults, the state typedef {RUN, EXC}, and the cause typedef {C_ILLOP, C_IRQ}.
REQ-040 A natural sub-module is pc_seq_prio, a combinational priority encoder for the RUN-state decision.

Verification
REQ-041 Reset low then release with no events: pc_next=00000000 during reset; next cycle pc_wr=1, pc_next=pc+4.
REQ-042 pc=00000010, stall=1, br_req=1, br_target=00000100: pc_wr=1, pc_next=00000100, flush_if=flush_id=1.
REQ-043 illop with id_pc=00000020: cycle 1 pc_wr=0, epc=00000020 after edge; cycle 2 pc_next=80000004, pc_wr=1.
REQ-044 irq with pc=80000010: no entry; after eret to 00000040, entry occurs one cycle later, pc_next=80000008, irq_pend=0.
REQ-045 br_req and illop in the same cycle: branch taken, state stays RUN, epc unchanged.
REQ-046 Reset asserted in EXC: state=RUN, pc_wr=0 immediately; no ILLOP write occurs.
